// File: rtl/block_avg_ctrl.sv
// Streaming block averager: sums 2^DIV_LOG2 samples, emits the half-up rounded, saturated mean.
// Optional macro BLOCK_AVG_MAX_EN adds a dmax output carrying the block's largest sample.
module block_avg_ctrl #(
  parameter int DIV_LOG2  = 3,
  parameter int OUT_WIDTH = 32,
  parameter int ACC_WIDTH = OUT_WIDTH + DIV_LOG2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic [OUT_WIDTH-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [DIV_LOG2-1:0]  sample_cnt
`ifdef BLOCK_AVG_MAX_EN
  ,
  output logic [OUT_WIDTH-1:0] dmax
`endif
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]           state_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [DIV_LOG2-1:0]  cnt_r;
  logic [OUT_WIDTH-1:0] dout_r;
  logic                 dout_valid_r;
  logic                 rdy_en_r;
  logic [ACC_WIDTH-1:0] sum_s;
  logic                 accept_s;
  logic                 last_s;
  logic                 handshake_s;

  // Shift-and-round division: quotient plus the first discarded bit, clamped to all-ones.
  function automatic logic [OUT_WIDTH-1:0] round_div(input logic [ACC_WIDTH-1:0] sum);
    logic [OUT_WIDTH:0] t;
    t = (OUT_WIDTH+1)'(sum[ACC_WIDTH-1:DIV_LOG2]) + (OUT_WIDTH+1)'(sum[DIV_LOG2-1]);
    return t[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : t[OUT_WIDTH-1:0];
  endfunction

  assign sum_s       = acc_r + ACC_WIDTH'(din);
  assign last_s      = (cnt_r == {DIV_LOG2{1'b1}});
  assign handshake_s = dout_valid_r && dout_ready;
  // In HOLD a sample may only enter on the cycle the result is handed off.
  assign din_ready   = rdy_en_r && !flush && ((state_r == ACCUM) ? 1'b1 : dout_ready);
  assign accept_s    = din_valid && din_ready;

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign sample_cnt = cnt_r;

  // Ready enable: keeps din_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
    end
  end

  // Block sequencing: accumulation, count, result capture and output hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ACCUM;
      acc_r        <= '0;
      cnt_r        <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else if (flush) begin
      state_r      <= ACCUM;
      acc_r        <= '0;
      cnt_r        <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      if (accept_s && last_s) begin
        dout_r       <= round_div(sum_s);
        dout_valid_r <= 1'b1;
        acc_r        <= '0;
        cnt_r        <= '0;
        state_r      <= HOLD;
      end else begin
        if (accept_s) begin
          acc_r <= sum_s;
          cnt_r <= cnt_r + DIV_LOG2'(1);
        end else begin
          acc_r <= acc_r;
          cnt_r <= cnt_r;
        end
        if (handshake_s) begin
          dout_valid_r <= 1'b0;
          state_r      <= ACCUM;
        end else begin
          dout_valid_r <= dout_valid_r;
          state_r      <= state_r;
        end
      end
    end
  end

`ifdef BLOCK_AVG_MAX_EN
  logic [OUT_WIDTH-1:0] max_r;
  logic [OUT_WIDTH-1:0] max_next_s;
  logic [OUT_WIDTH-1:0] dmax_r;

  // Running maximum including the sample currently on din.
  always_comb begin
    max_next_s = max_r;
    if (din > max_r) begin
      max_next_s = din;
    end else begin
      max_next_s = max_r;
    end
  end

  // Block maximum tracking, captured alongside dout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      max_r  <= '0;
      dmax_r <= '0;
    end else if (flush) begin
      max_r <= '0;
    end else if (accept_s && last_s) begin
      dmax_r <= max_next_s;
      max_r  <= '0;
    end else if (accept_s) begin
      max_r <= max_next_s;
    end else begin
      max_r <= max_r;
    end
  end

  assign dmax = dmax_r;
`endif

endmodule

// File: tb/tb_block_avg_ctrl.sv
// Self-checking bench for block_avg_ctrl (DIV_LOG2=3, OUT_WIDTH=8): vector table,
// directed hold/flush/reset sequences, and a randomized run against a block-sum model.
module tb_block_avg_ctrl;

  localparam int DL = 3;
  localparam int OW = 8;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic [OW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [DL-1:0] sample_cnt;
`ifdef BLOCK_AVG_MAX_EN
  logic [OW-1:0] dmax;
`endif

  int total = 0;
  int bad   = 0;

  block_avg_ctrl #(.DIV_LOG2(DL), .OUT_WIDTH(OW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .sample_cnt(sample_cnt)
`ifdef BLOCK_AVG_MAX_EN
    , .dmax(dmax)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s [8];
    int         avg;
    int         mx;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Feed n samples of val with a fixed dout_ready, one per cycle; starts/ends 1ns after an edge.
  task automatic feed(input int val, input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      din = OW'(val); din_valid = 1'b1; dout_ready = rdy;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic apply_block(input vec_t v, input string tag);
    dout_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      din = v.s[i]; din_valid = 1'b1; #1;
      chk({tag, "_din_ready"}, int'(din_ready), 1);
      @(posedge clk); #1;
      if (i < N - 1) begin
        chk({tag, "_cnt"}, int'(sample_cnt), i + 1);
        chk({tag, "_early_valid"}, int'(dout_valid), 0);
      end
    end
    din_valid = 1'b0;
    chk({tag, "_valid"}, int'(dout_valid), 1);
    chk({tag, "_dout"}, int'(dout), v.avg);
    chk({tag, "_cnt_wrap"}, int'(sample_cnt), 0);
`ifdef BLOCK_AVG_MAX_EN
    chk({tag, "_dmax"}, int'(dmax), v.mx);
`endif
    @(posedge clk); #1;
    chk({tag, "_valid_1cyc"}, int'(dout_valid), 0);
  endtask

  initial begin
    int q_avg [$];
    int q_max [$];
    int sum, cnt, mx;
    logic exp_rdy, acc, hs;

    // Directed vectors: {samples, rounded mean, block max}.
    vecs[0].s = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};           vecs[0].avg = 5;   vecs[0].mx = 8;
    vecs[1].s = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd7};           vecs[1].avg = 4;   vecs[1].mx = 7;
    vecs[2].s = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}; vecs[2].avg = 255; vecs[2].mx = 255;
    vecs[3].s = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};           vecs[3].avg = 0;   vecs[3].mx = 0;
    vecs[4].s = '{8'd9, 8'd1, 8'd250, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};         vecs[4].avg = 35;  vecs[4].mx = 250;
    vecs[5].s = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3};           vecs[5].avg = 0;   vecs[5].mx = 3;

    resetn = 1'b0; flush = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_cnt", int'(sample_cnt), 0);
    chk("rst_din_ready", int'(din_ready), 0);
    #11 resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_din_ready", int'(din_ready), 1);

    for (int k = 0; k < 6; k++) apply_block(vecs[k], $sformatf("vec%0d", k));

    // Result held while consumer stalls; hand-off cycle also accepts the next sample.
    feed(6, N, 1'b0);
    chk("hold_valid0", int'(dout_valid), 1);
    chk("hold_dout0", int'(dout), 6);
    din = 8'd7; din_valid = 1'b1; dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_din_ready", int'(din_ready), 0);
      @(posedge clk); #1;
      chk("hold_valid", int'(dout_valid), 1);
      chk("hold_dout", int'(dout), 6);
      chk("hold_cnt", int'(sample_cnt), 0);
    end
    dout_ready = 1'b1; #1;
    chk("handoff_din_ready", int'(din_ready), 1);
    @(posedge clk); #1;
    chk("handoff_valid", int'(dout_valid), 0);
    chk("handoff_cnt", int'(sample_cnt), 1);
    feed(7, N - 1, 1'b1);
    chk("after_hold_valid", int'(dout_valid), 1);
    chk("after_hold_dout", int'(dout), 7);
    @(posedge clk); #1;

    // Flush discards a partial block; dout keeps its last value.
    feed(200, 3, 1'b1);
    chk("pre_flush_cnt", int'(sample_cnt), 3);
    flush = 1'b1; din = 8'd200; din_valid = 1'b1; #1;
    chk("flush_din_ready", int'(din_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; din_valid = 1'b0;
    chk("flush_cnt", int'(sample_cnt), 0);
    chk("flush_valid", int'(dout_valid), 0);
    chk("flush_dout_kept", int'(dout), 7);
    begin
      vec_t v10;
      for (int i = 0; i < N; i++) v10.s[i] = 8'd10;
      v10.avg = 10; v10.mx = 10;
      apply_block(v10, "post_flush");
    end

    // Asynchronous reset in the middle of a block.
    feed(100, 5, 1'b1);
    chk("pre_rst_cnt", int'(sample_cnt), 5);
    resetn = 1'b0; #1;
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_valid", int'(dout_valid), 0);
    chk("mid_rst_cnt", int'(sample_cnt), 0);
    @(posedge clk); @(posedge clk); #3;
    resetn = 1'b1; #1;
    chk("rel_din_ready_low", int'(din_ready), 0);
    @(posedge clk); #1;
    chk("rel_din_ready_high", int'(din_ready), 1);
    begin
      vec_t v3;
      for (int i = 0; i < N; i++) v3.s[i] = 8'd3;
      v3.avg = 3; v3.mx = 3;
      apply_block(v3, "post_rst");
    end

    // Randomized traffic against a block-sum model.
    sum = 0; cnt = 0; mx = 0;
    for (int c = 0; c < 800; c++) begin
      din        = OW'($urandom_range(0, 255));
      din_valid  = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 2) != 0);
      if (c >= 780) din_valid = 1'b0;
      if (c >= 780) dout_ready = 1'b1;
      #1;
      exp_rdy = (q_avg.size() == 0) || dout_ready;
      chk("rnd_valid", int'(dout_valid), int'(q_avg.size() != 0));
      chk("rnd_din_ready", int'(din_ready), int'(exp_rdy));
      hs  = (q_avg.size() != 0) && dout_ready;
      acc = din_valid && exp_rdy;
      if (hs) begin
        chk("rnd_dout", int'(dout), q_avg[0]);
`ifdef BLOCK_AVG_MAX_EN
        chk("rnd_dmax", int'(dmax), q_max[0]);
`endif
        void'(q_avg.pop_front());
        void'(q_max.pop_front());
      end
      if (acc) begin
        sum += int'(din);
        if (int'(din) > mx) mx = int'(din);
        cnt++;
        if (cnt == N) begin
          q_avg.push_back(((sum + N / 2) / N > 255) ? 255 : (sum + N / 2) / N);
          q_max.push_back(mx);
          sum = 0; cnt = 0; mx = 0;
        end
      end
      @(posedge clk); #1;
      chk("rnd_cnt", int'(sample_cnt), cnt);
    end
    chk("rnd_drained", q_avg.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
